// File: rtl/out_channel_reader_if.sv
// Output-channel bundle: processor write side, consumer read stream, and status.
// The design takes the slave view; the processor/consumer side takes the master view.
interface out_channel_reader_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 4,
  parameter int CountWidth         = 16
);
  localparam int CW = $clog2(NOut + 1);

  logic                          outWrite;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outFull;
  logic                          readValid;
  logic [MemoryElementWidth-1:0] readData;
  logic                          readReady;
  logic [CW-1:0]                 count;
  logic                          overflow;
  logic [CountWidth-1:0]         accepted;
  logic                          finished;
  logic                          drained;

  modport master (
    output outWrite, outData, readReady, finished,
    input  outFull, readValid, readData, count, overflow, accepted, drained
  );

  modport slave (
    input  outWrite, outData, readReady, finished,
    output outFull, readValid, readData, count, overflow, accepted, drained
  );
endinterface

// File: rtl/out_channel_reader.sv
// Circular buffer that captures processor `out` words and streams them to a consumer,
// one cycle write-to-read latency; stalls the processor via outFull and flags dropped writes.
module out_channel_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 4,
  parameter int CountWidth         = 16
) (
  input logic                 clock,
  input logic                 reset,
  out_channel_reader_if.slave ch
);
  localparam int CW = $clog2(NOut + 1);
  localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(NOut);
  localparam logic [PW-1:0] LAST_PTR = PW'(NOut - 1);

  logic [MemoryElementWidth-1:0] store_q [NOut];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CountWidth-1:0] accepted_q, accepted_d;
  logic                  overflow_q, overflow_d;
  logic                  finished_seen_q, finished_seen_d;
  logic                  drained_q, drained_d;
  logic                  pop, push;

  assign pop  = (count_q != '0) && ch.readReady;
  // A full buffer still takes a write when the oldest word leaves in the same cycle.
  assign push = ch.outWrite && ((count_q != FULL_CNT) || pop);

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    accepted_d      = accepted_q;
    overflow_d      = overflow_q | (ch.outWrite && !push);
    finished_seen_d = finished_seen_q | ch.finished;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (accepted_q != '1) accepted_d = accepted_q + CountWidth'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    drained_d = finished_seen_d && (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      accepted_q      <= '0;
      overflow_q      <= 1'b0;
      finished_seen_q <= 1'b0;
      drained_q       <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      accepted_q      <= accepted_d;
      overflow_q      <= overflow_d;
      finished_seen_q <= finished_seen_d;
      drained_q       <= drained_d;
    end
  end

  // Storage is deliberately not reset; readValid masks stale contents.
  always_ff @(posedge clock) begin
    if (push) store_q[wr_ptr_q] <= ch.outData;
  end

  assign ch.readValid = (count_q != '0);
  assign ch.readData  = store_q[rd_ptr_q];
  assign ch.outFull   = (count_q == FULL_CNT);
  assign ch.count     = count_q;
  assign ch.overflow  = overflow_q;
  assign ch.accepted  = accepted_q;
  assign ch.drained   = drained_q;
endmodule

// File: tb/tb_out_channel_reader.sv
// Directed bench for out_channel_reader with NOut=4: single word, overflow, wrap, full push/pop,
// drained tracking and mid-operation reset.
module tb_out_channel_reader;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  out_channel_reader_if #(.MemoryElementWidth(12), .NOut(4), .CountWidth(16)) ch ();

  out_channel_reader #(.MemoryElementWidth(12), .NOut(4), .CountWidth(16)) dut (
    .clock (clock),
    .reset (reset),
    .ch    (ch.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ch.outWrite  = 1'b0;
    ch.outData   = '0;
    ch.readReady = 1'b0;
    ch.finished  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic wr(input logic [11:0] d);
    ch.outWrite = 1'b1;
    ch.outData  = d;
    step();
    ch.outWrite = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [11:0] d);
    ch.readReady = 1'b1;
    chk({tag, "_valid"}, 32'(ch.readValid), 32'd1);
    chk({tag, "_data"}, 32'(ch.readData), 32'(d));
    step();
    ch.readReady = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    ch.outWrite  = 1'b0;
    ch.outData   = '0;
    ch.readReady = 1'b0;
    ch.finished  = 1'b0;
    #12;
    chk("rst_valid",    32'(ch.readValid), 32'd0);
    chk("rst_count",    32'(ch.count),     32'd0);
    chk("rst_full",     32'(ch.outFull),   32'd0);
    chk("rst_overflow", 32'(ch.overflow),  32'd0);
    chk("rst_accepted", 32'(ch.accepted),  32'd0);
    chk("rst_drained",  32'(ch.drained),   32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Single word: no same-cycle bypass.
    ch.outWrite = 1'b1;
    ch.outData  = 12'd1;
    chk("single_nobypass", 32'(ch.readValid), 32'd0);
    step();
    ch.outWrite = 1'b0;
    chk("single_valid",    32'(ch.readValid), 32'd1);
    chk("single_data",     32'(ch.readData),  32'd1);
    chk("single_count",    32'(ch.count),     32'd1);
    chk("single_accepted", 32'(ch.accepted),  32'd1);
    ch.readReady = 1'b1;
    step();
    ch.readReady = 1'b0;
    chk("single_empty_valid", 32'(ch.readValid), 32'd0);
    chk("single_empty_count", 32'(ch.count),     32'd0);

    // Fill and overflow.
    do_reset();
    wr(12'd10); wr(12'd20); wr(12'd30); wr(12'd40);
    chk("fill_full",  32'(ch.outFull), 32'd1);
    chk("fill_count", 32'(ch.count),   32'd4);
    chk("fill_no_ovf", 32'(ch.overflow), 32'd0);
    wr(12'd50);
    chk("ovf_flag",     32'(ch.overflow), 32'd1);
    chk("ovf_count",    32'(ch.count),    32'd4);
    chk("ovf_accepted", 32'(ch.accepted), 32'd4);
    rd_expect("ovf_rd0", 12'd10);
    rd_expect("ovf_rd1", 12'd20);
    rd_expect("ovf_rd2", 12'd30);
    rd_expect("ovf_rd3", 12'd40);
    chk("ovf_empty",  32'(ch.readValid), 32'd0);
    chk("ovf_sticky", 32'(ch.overflow),  32'd1);
    chk("ovf_notfull", 32'(ch.outFull),  32'd0);

    // Wrap-around.
    do_reset();
    wr(12'd1); wr(12'd2); wr(12'd3);
    rd_expect("wrap_a0", 12'd1);
    rd_expect("wrap_a1", 12'd2);
    rd_expect("wrap_a2", 12'd3);
    wr(12'd4); wr(12'd5); wr(12'd6); wr(12'd7);
    chk("wrap_full", 32'(ch.outFull), 32'd1);
    rd_expect("wrap_b0", 12'd4);
    rd_expect("wrap_b1", 12'd5);
    rd_expect("wrap_b2", 12'd6);
    rd_expect("wrap_b3", 12'd7);
    chk("wrap_wrptr",    32'(dut.wr_ptr_q),  32'd3);
    chk("wrap_rdptr",    32'(dut.rd_ptr_q),  32'd3);
    chk("wrap_overflow", 32'(ch.overflow),   32'd0);
    chk("wrap_empty",    32'(ch.readValid),  32'd0);

    // Full with simultaneous push and pop.
    do_reset();
    wr(12'd10); wr(12'd20); wr(12'd30); wr(12'd40);
    ch.outWrite  = 1'b1;
    ch.outData   = 12'd99;
    ch.readReady = 1'b1;
    chk("pp_head", 32'(ch.readData), 32'd10);
    step();
    ch.outWrite  = 1'b0;
    ch.readReady = 1'b0;
    chk("pp_count",    32'(ch.count),    32'd4);
    chk("pp_overflow", 32'(ch.overflow), 32'd0);
    chk("pp_accepted", 32'(ch.accepted), 32'd5);
    rd_expect("pp_rd0", 12'd20);
    rd_expect("pp_rd1", 12'd30);
    rd_expect("pp_rd2", 12'd40);
    rd_expect("pp_rd3", 12'd99);
    chk("pp_empty", 32'(ch.readValid), 32'd0);

    // Finished / drained.
    do_reset();
    wr(12'd7);
    ch.finished = 1'b1;
    step();
    ch.finished = 1'b0;
    chk("drn_pending", 32'(ch.drained), 32'd0);
    chk("drn_count",   32'(ch.count),   32'd1);
    rd_expect("drn_rd7", 12'd7);
    chk("drn_set", 32'(ch.drained), 32'd1);
    wr(12'd8);
    chk("drn_cleared", 32'(ch.drained), 32'd0);
    rd_expect("drn_rd8", 12'd8);
    chk("drn_reset", 32'(ch.drained), 32'd1);

    // Reset mid-operation, asserted for part of a cycle.
    do_reset();
    wr(12'd1); wr(12'd2); wr(12'd3); wr(12'd4); wr(12'd5);
    rd_expect("mid_rd", 12'd1);
    chk("mid_pre_count",    32'(ch.count),    32'd3);
    chk("mid_pre_overflow", 32'(ch.overflow), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_count",    32'(ch.count),     32'd0);
    chk("mid_valid",    32'(ch.readValid), 32'd0);
    chk("mid_overflow", 32'(ch.overflow),  32'd0);
    chk("mid_accepted", 32'(ch.accepted),  32'd0);
    chk("mid_drained",  32'(ch.drained),   32'd0);
    #1;
    reset = 1'b1;
    step();
    step();
    chk("post_count",    32'(ch.count),     32'd0);
    chk("post_valid",    32'(ch.readValid), 32'd0);
    chk("post_overflow", 32'(ch.overflow),  32'd0);
    chk("post_accepted", 32'(ch.accepted),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
